// File: rtl/alu_op_issue.sv
// alu_op_issue -- producer end of the ALU interface.
//
// Decodes RV32I OP, OP-IMM, LUI and AUIPC instructions into an
// operand1/operand2/aluCntrl bundle plus destination info. The bundle is
// handed to the execute stage over a valid/ready handshake.
//
// A two-entry buffer (main + skid) sits between decode and the outputs.
// This lets instrReady be a plain register and still sustain one
// operation per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous flush, empties both entries
//   instr, pc         instruction word and its address
//   rs1Data, rs2Data  register-file read data for instr rs1/rs2
//   instrValid        upstream offers an instruction
//   instrReady        this block accepts (registered, == !skid full)
//   operand1/2        ALU operands
//   aluCntrl          ALU operation
//   rd, rdWe          destination register and write enable
//   illegal           instruction not handled here (issued as a slot)
//   opValid, opReady  output handshake to the execute stage
module alu_op_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic            instrValid,
  output logic            instrReady,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [3:0]      aluCntrl,
  output logic [4:0]      rd,
  output logic            rdWe,
  output logic            illegal,
  output logic            opValid,
  input  logic            opReady
);

  // ALU encodings (shared with loopyV_constants.svh). The encoding equals
  // {funct7[5], funct3} of the matching OP instruction, which the decoder
  // below relies on.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } slot_t;

  slot_t dec_slot;
  slot_t main_reg;
  slot_t skid_reg;
  logic  main_valid_reg;
  logic  skid_valid_reg;
  logic  instr_ready_reg;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        legal;
  logic [XLEN-1:0] op1_raw;
  logic [XLEN-1:0] op2_raw;
  logic [3:0]      alu_raw;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  // ---------------------------------------------------------------- decode
  always_comb begin
    legal   = 1'b0;
    alu_raw = ALU_ADD;
    op1_raw = '0;
    op2_raw = '0;
    case (opcode)
      OPC_OP: begin
        op1_raw = rs1Data;
        op2_raw = rs2Data;
        if (funct7 == 7'b0000000) begin
          legal   = 1'b1;
          alu_raw = {1'b0, funct3};
        end else if (funct7 == 7'b0100000 &&
                     (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal   = 1'b1;
          alu_raw = {1'b1, funct3};   // SUB / SRA
        end
      end
      OPC_OP_IMM: begin
        op1_raw = rs1Data;
        if (funct3 == 3'b001) begin
          legal   = (funct7 == 7'b0000000);
          alu_raw = ALU_SLL;
          op2_raw = shamt;
        end else if (funct3 == 3'b101) begin
          legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          alu_raw = {funct7[5], 3'b101};  // SRLI / SRAI
          op2_raw = shamt;
        end else begin
          legal   = 1'b1;
          alu_raw = {1'b0, funct3};
          op2_raw = imm_i;
        end
      end
      OPC_LUI: begin
        legal   = 1'b1;
        op2_raw = imm_u;
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        op1_raw = pc;
        op2_raw = imm_u;
      end
      default: legal = 1'b0;
    endcase

    // Illegal instructions still occupy a slot, with a neutral payload.
    dec_slot.rd  = instr[11:7];
    dec_slot.ill = !legal;
    dec_slot.we  = legal && (instr[11:7] != 5'd0);
    dec_slot.op1 = legal ? op1_raw : '0;
    dec_slot.op2 = legal ? op2_raw : '0;
    dec_slot.alu = legal ? alu_raw : 4'b0000;
  end

  // ---------------------------------------------------------------- buffer
  logic accept;
  logic drain;

  assign accept = instrValid && instr_ready_reg;
  assign drain  = main_valid_reg && opReady;

  // instr_ready_reg is low exactly when the skid entry is full, so an
  // accept never arrives while skid holds data; that case needs no branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_reg        <= '0;
      skid_reg        <= '0;
      main_valid_reg  <= 1'b0;
      skid_valid_reg  <= 1'b0;
      instr_ready_reg <= 1'b1;
    end else if (flush) begin
      main_valid_reg  <= 1'b0;
      skid_valid_reg  <= 1'b0;
      instr_ready_reg <= 1'b1;
    end else if (!main_valid_reg || drain) begin
      if (skid_valid_reg) begin
        main_reg        <= skid_reg;
        main_valid_reg  <= 1'b1;
        skid_valid_reg  <= 1'b0;
        instr_ready_reg <= 1'b1;
      end else begin
        main_valid_reg <= accept;
        if (accept) begin
          main_reg <= dec_slot;
        end
      end
    end else if (accept) begin
      skid_reg        <= dec_slot;
      skid_valid_reg  <= 1'b1;
      instr_ready_reg <= 1'b0;
    end
  end

  assign instrReady = instr_ready_reg;
  assign opValid    = main_valid_reg;
  assign operand1   = main_reg.op1;
  assign operand2   = main_reg.op2;
  assign aluCntrl   = main_reg.alu;
  assign rd         = main_reg.rd;
  assign rdWe       = main_reg.we;
  assign illegal    = main_reg.ill;

endmodule
